framebuffer_fill: RTL and testbench
===================================

Name: framebuffer_fill

Overview:
- Single-clock, parametrised successor to the dual-bank 1 bpp framebuffer.
- Width, height, bits per pixel and write-word width are all generic.
- Adds a hardware fill (clear-to-colour) engine with a busy/done handshake, a valid/ready write port and a fixed-latency read port with valid.
- Sits between the drawing/blitter logic (write side) and the video timing/scanout logic (read side).

Parameters:
- WIDTH, 1024: pixels per line; power of two, >= WIDTH_IN.
- HEIGHT, 512: lines; power of two.
- BPP, 1: bits per pixel; 1, 2, 4 or 8.
- WIDTH_IN, 4: pixels per write word; power of two.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  write request.
- in_ready  out  1  write accepted when high with in_valid.
- in_x  in  $clog2(WIDTH)  pixel x; low $clog2(WIDTH_IN) bits ignored.
- in_y  in  $clog2(HEIGHT)  line.
- in_data  in  WIDTH_IN*BPP  pixel i at bits [i*BPP +: BPP]; pixel 0 is the leftmost.
- fill_start  in  1  start fill (level sampled).
- fill_colour  in  BPP  fill colour, sampled with fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when fill completes.
- out_req  in  1  read request.
- out_x  in  $clog2(WIDTH)  read x.
- out_y  in  $clog2(HEIGHT)  read y.
- out_valid  out  1  out_data is valid.
- out_data  out  BPP  read pixel.

Behaviour:
- Storage and addressing:
  - Storage is DEPTH = WIDTH*HEIGHT/WIDTH_IN words of WIDTH_IN*BPP bits, inferred as synchronous RAM.
  - Word address = {y, x[$clog2(WIDTH)-1:$clog2(WIDTH_IN)]}.
- Reset values: in_ready=1, fill_busy=0, fill_done=0, out_valid=0, out_data=0, FSM=IDLE. RAM contents are not reset.
- Write path:
  - A write occurs in the cycle in_valid && in_ready.
  - in_ready = (state==IDLE); there is no combinational path from in_valid.
- Read path:
  - out_req in cycle N gives out_valid=1 and out_data in cycle N+2: address register, then RAM read plus pixel-select register.
  - Fully pipelined; one request per cycle is accepted.
  - out_valid=0 in cycles with no matching request; out_data holds its last value.
- Read-during-write to the same word in the same cycle returns old data.
- Fill FSM:
  - IDLE: fill_start=1 latches fill_colour, clears the address counter to 0 and moves to FILL.
  - FILL: fill_busy=1; each cycle writes fill_colour replicated WIDTH_IN times to the counter address, then increments the counter. The write to address DEPTH-1 moves to DONE.
  - DONE: fill_done=1 for exactly one cycle, then returns to IDLE. fill_busy=0 in DONE.
  - A fill takes DEPTH cycles of FILL plus 1 cycle of DONE.
- Boundary conditions:
  - fill_start while in FILL or DONE is ignored. It is not queued.
  - in_valid && fill_start in the same IDLE cycle: the write is accepted that cycle and the fill starts next cycle, so the fill overwrites the written pixels.
  - Reads are unaffected by a fill and return a mix of old and fill data.
  - The address counter is $clog2(DEPTH) bits. It must not wrap back into FILL; the final address is detected explicitly.
  - rst asserted mid-fill: immediately returns to IDLE with fill_busy=0. No fill_done pulse. RAM is left partially filled.

Optional Feature:
Macro FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN.
- Defined:
  - RAM depth doubles to two pages.
  - Adds ports swap_req (in, 1), swap_ack (out, 1) and page (out, 1; front page, reset 0).
  - Writes and fills target page ~page; reads target page, sampled with out_req.
  - swap_req sets a pending flag. Page toggles in the first cycle with pending && state==IDLE; swap_ack pulses that cycle and pending clears.
  - A swap requested during a fill therefore takes effect after fill_done.
- Undefined: single page; swap ports are absent.

Test Plan:
All scenarios use WIDTH=16, HEIGHT=8, BPP=2, WIDTH_IN=4.
- Reset, then a write at (x=4, y=3) with in_data=8'hE4, then reads of x=4..7, y=3 -> out_data 0,1,2,3 on successive cycles, each 2 cycles after its request.
- fill_start with fill_colour=2'b10 -> fill_busy high for 32 cycles; in_ready=0 throughout; fill_done high for exactly 1 cycle; every pixel then reads back 2'b10.
- in_valid and fill_start in the same cycle at (0,0) with data 8'hFF, fill colour 0 -> write is accepted, then (0,0) reads back 0 after fill_done.
- rst pulsed at fill cycle 10 -> fill_busy=0 immediately, no fill_done, and words 10..31 still hold their pre-fill values.
- Back-to-back out_req on 8 cycles -> 8 consecutive out_valid cycles starting 2 cycles after the first request; a fill_start during busy is ignored, so only one fill_done.
- With FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN defined: fill back page with 2'b01, with swap_req asserted at fill cycle 5 -> swap_ack is asserted 1 cycle after fill_done, page=1, and reads then return 2'b01.

Source files
------------

// File: rtl/framebuffer_fill.sv
// Parametrised framebuffer with a clear-to-colour fill engine, valid/ready write port and 2-cycle read port.
// Define FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN to add a second page with swap_req/swap_ack page flipping.
module framebuffer_fill #(
   parameter int WIDTH    = 1024,
   parameter int HEIGHT   = 512,
   parameter int BPP      = 1,
   parameter int WIDTH_IN = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [$clog2(WIDTH)-1:0]    in_x,
   input  logic [$clog2(HEIGHT)-1:0]   in_y,
   input  logic [WIDTH_IN*BPP-1:0]     in_data,
   input  logic                        fill_start,
   input  logic [BPP-1:0]              fill_colour,
   output logic                        fill_busy,
   output logic                        fill_done,
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   input  logic                        swap_req,
   output logic                        swap_ack,
   output logic                        page,
`endif
   input  logic                        out_req,
   input  logic [$clog2(WIDTH)-1:0]    out_x,
   input  logic [$clog2(HEIGHT)-1:0]   out_y,
   output logic                        out_valid,
   output logic [BPP-1:0]              out_data
);
   localparam int XW     = $clog2(WIDTH);
   localparam int SW     = $clog2(WIDTH_IN);
   localparam int SELW   = (SW == 0) ? 1 : SW;
   localparam int DW     = WIDTH_IN * BPP;
   localparam int DEPTH  = WIDTH * HEIGHT / WIDTH_IN;
   localparam int AW     = $clog2(DEPTH);
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   localparam int RAW    = AW + 1;
`else
   localparam int RAW    = AW;
`endif
   localparam int RDEPTH = 1 << RAW;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [BPP-1:0]    colour_q, colour_d;
   logic              rd_valid1_q, rd_valid1_d;
   logic [RAW-1:0]    rd_addr_q, rd_addr_d;
   logic [SELW-1:0]   rd_sel1_q, rd_sel1_d;
   logic              out_valid_q, out_valid_d;
   logic [SELW-1:0]   rd_sel2_q, rd_sel2_d;
   logic              have_data_q, have_data_d;
   logic [DW-1:0]     rd_word_q;
   logic              wr_en;
   logic [RAW-1:0]    wr_addr;
   logic [DW-1:0]     wr_data;
   logic [DW-1:0]     ram [RDEPTH];
   logic              unused_in_x;

   // Sub-word x bits only select a pixel on the read side.
   assign unused_in_x = ^in_x;

`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   logic page_q, page_d, pending_q, pending_d;
   assign page = page_q;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      colour_d = colour_q;
      case (state_q)
         IDLE: if (fill_start) begin
            state_d  = FILL;
            cnt_d    = '0;
            colour_d = fill_colour;
         end
         FILL: begin
            // Final word detected explicitly so the counter never wraps back into FILL.
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      fill_busy = (state_q == FILL);
      fill_done = (state_q == DONE);
      out_valid = out_valid_q;
      out_data  = have_data_q ? rd_word_q[rd_sel2_q*BPP +: BPP] : '0;
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
      swap_ack  = pending_q && (state_q == IDLE);
`endif
   end

`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   always_comb begin
      page_d    = page_q ^ swap_ack;
      pending_d = (pending_q && !swap_ack) || swap_req;
   end
`endif

   always_comb begin
      wr_en   = 1'b0;
      wr_data = in_data;
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
      wr_addr   = {~page_q, in_y, in_x[XW-1:SW]};
      rd_addr_d = {page_q, out_y, out_x[XW-1:SW]};
`else
      wr_addr   = {in_y, in_x[XW-1:SW]};
      rd_addr_d = {out_y, out_x[XW-1:SW]};
`endif
      if (state_q == FILL) begin
         wr_en   = 1'b1;
         wr_data = {WIDTH_IN{colour_q}};
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
         wr_addr = {~page_q, cnt_q};
`else
         wr_addr = cnt_q;
`endif
      end else if (state_q == IDLE && in_valid) begin
         wr_en = 1'b1;
      end
      rd_valid1_d = out_req;
      rd_sel1_d   = (SW == 0) ? '0 : out_x[SELW-1:0];
      out_valid_d = rd_valid1_q;
      rd_sel2_d   = rd_valid1_q ? rd_sel1_q : rd_sel2_q;
      have_data_d = have_data_q || rd_valid1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         colour_q    <= '0;
         rd_valid1_q <= 1'b0;
         rd_addr_q   <= '0;
         rd_sel1_q   <= '0;
         out_valid_q <= 1'b0;
         rd_sel2_q   <= '0;
         have_data_q <= 1'b0;
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
         page_q      <= 1'b0;
         pending_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         colour_q    <= colour_d;
         rd_valid1_q <= rd_valid1_d;
         rd_addr_q   <= rd_addr_d;
         rd_sel1_q   <= rd_sel1_d;
         out_valid_q <= out_valid_d;
         rd_sel2_q   <= rd_sel2_d;
         have_data_q <= have_data_d;
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
         page_q      <= page_d;
         pending_q   <= pending_d;
`endif
      end
   end

   // RAM has no reset; the read sees pre-write contents on a same-word collision.
   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      if (rd_valid1_q) rd_word_q <= ram[rd_addr_q];
   end
endmodule

// File: tb/tb_framebuffer_fill.sv
// Directed self-checking bench for framebuffer_fill at 16x8, 2 bpp, 4 pixels per word.
module tb_framebuffer_fill;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_x = '0;
   logic [2:0] in_y = '0;
   logic [7:0] in_data = '0;
   logic       fill_start = 1'b0;
   logic [1:0] fill_colour = '0;
   logic       fill_busy, fill_done;
   logic       out_req = 1'b0;
   logic [3:0] out_x = '0;
   logic [2:0] out_y = '0;
   logic       out_valid;
   logic [1:0] out_data;
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   logic       swap_req = 1'b0;
   logic       swap_ack, page;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int rd_x [0:127];
   int rd_y [0:127];
   int rd_e [0:127];

   framebuffer_fill #(.WIDTH(16), .HEIGHT(8), .BPP(2), .WIDTH_IN(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_data(in_data),
      .fill_start(fill_start), .fill_colour(fill_colour), .fill_busy(fill_busy), .fill_done(fill_done),
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
      .swap_req(swap_req), .swap_ack(swap_ack), .page(page),
`endif
      .out_req(out_req), .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int pat(input int w);
      return (w * 37 + 5) & 255;
   endfunction

   // Issues n back-to-back reads from rd_x/rd_y and expects rd_e two cycles later each.
   task automatic run_reads(input int n, input string tag);
      bit exp_v;
      for (int k = 0; k <= n + 2; k++) begin
         if (k < n) begin
            out_req = 1'b1;
            out_x   = 4'(rd_x[k]);
            out_y   = 3'(rd_y[k]);
         end else begin
            out_req = 1'b0;
         end
         exp_v = (k >= 2) && (k - 2 < n);
         n_checks++;
         if (out_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s_valid cycle %0d: out_valid=%b expected %b", tag, k, out_valid, exp_v);
         end
         if (exp_v) begin
            n_checks++;
            if (out_data !== 2'(rd_e[k-2])) begin
               n_fail++;
               $display("FAIL %s_data (x=%0d,y=%0d): out_data=%0d expected %0d",
                        tag, rd_x[k-2], rd_y[k-2], out_data, rd_e[k-2]);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_checks += 5;
      if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      if (fill_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_fill_busy: got %b expected 0", fill_busy); end
      if (fill_done !== 1'b0)  begin n_fail++; $display("FAIL reset_fill_done: got %b expected 0", fill_done); end
      if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (out_data !== 2'd0)   begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
      n_checks += 2;
      if (page !== 1'b0)     begin n_fail++; $display("FAIL reset_page: got %b expected 0", page); end
      if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_swap_ack: got %b expected 0", swap_ack); end
`endif
   endtask

   task automatic test_write_read;
      in_valid = 1'b1; in_x = 4'd4; in_y = 3'd3; in_data = 8'hE4;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin rd_x[i] = 4 + i; rd_y[i] = 3; rd_e[i] = i; end
      run_reads(4, "write_read");
   endtask

   task automatic test_fill;
      int busy = 0;
      int done = 0;
      fill_start = 1'b1; fill_colour = 2'b10;
      tick();
      fill_start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (fill_busy || fill_done) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready cycle %0d: got %b expected 0", c, in_ready); end
         end
         if (fill_busy) busy++;
         if (fill_done) done++;
         tick();
      end
      n_checks += 2;
      if (busy != 32) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d expected 32", busy); end
      if (done != 1)  begin n_fail++; $display("FAIL fill_done_pulses: got %0d expected 1", done); end
      for (int i = 0; i < 128; i++) begin rd_x[i] = i % 16; rd_y[i] = i / 16; rd_e[i] = 2; end
      run_reads(128, "fill_read");
   endtask

   task automatic test_same_cycle;
      int done = 0;
      in_valid = 1'b1; in_x = 4'd0; in_y = 3'd0; in_data = 8'hFF;
      fill_start = 1'b1; fill_colour = 2'b00;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0; fill_start = 1'b0;
      n_checks++;
      if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy: got %b expected 1", fill_busy); end
      for (int c = 0; c < 40; c++) begin
         if (fill_done) done++;
         tick();
      end
      n_checks++;
      if (done != 1) begin n_fail++; $display("FAIL same_cycle_done: got %0d expected 1", done); end
      for (int i = 0; i < 4; i++) begin rd_x[i] = i; rd_y[i] = 0; rd_e[i] = 0; end
      run_reads(4, "same_cycle");
   endtask

   task automatic test_reset_mid_fill;
      int busy = 0;
      int done = 0;
      int w;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; in_y = 3'(i / 4); in_x = 4'((i % 4) * 4); in_data = 8'(pat(i));
         tick();
      end
      in_valid = 1'b0;
      fill_start = 1'b1; fill_colour = 2'b11;
      tick();
      fill_start = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL midfill_busy_before: got %b expected 1", fill_busy); end
      rst = 1'b1;
      #1;
      n_checks += 2;
      if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL midfill_busy_async: got %b expected 0", fill_busy); end
      if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midfill_ready_async: got %b expected 1", in_ready); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (fill_busy) busy++;
         if (fill_done) done++;
         tick();
      end
      n_checks += 2;
      if (done != 0) begin n_fail++; $display("FAIL midfill_no_done: got %0d pulses expected 0", done); end
      if (busy != 0) begin n_fail++; $display("FAIL midfill_no_busy: got %0d cycles expected 0", busy); end
      for (int i = 0; i < 128; i++) begin
         rd_x[i] = i % 16; rd_y[i] = i / 16;
         w = rd_y[i] * 4 + rd_x[i] / 4;
         rd_e[i] = (w < 10) ? 3 : ((pat(w) >> (2 * (rd_x[i] % 4))) & 3);
      end
      run_reads(128, "midfill_read");
   endtask

   task automatic test_back_to_back;
      int busy = 0;
      int done = 0;
      int w;
      for (int i = 0; i < 8; i++) begin
         rd_x[i] = i; rd_y[i] = 2;
         w = 8 + i / 4;
         rd_e[i] = (w < 10) ? 3 : ((pat(w) >> (2 * (i % 4))) & 3);
      end
      run_reads(8, "b2b_read");
      fill_colour = 2'b01;
      for (int c = 0; c < 80; c++) begin
         fill_start = (c < 20);
         if (fill_busy) busy++;
         if (fill_done) done++;
         tick();
      end
      fill_start = 1'b0;
      n_checks += 2;
      if (busy != 32) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 32", busy); end
      if (done != 1)  begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected 1", done); end
      for (int i = 0; i < 4; i++) begin rd_x[i] = 12 + i; rd_y[i] = 7; rd_e[i] = 1; end
      run_reads(4, "b2b_fill_read");
   endtask

`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
   task automatic test_double_buffer;
      int done_at = -1;
      int ack_at = -1;
      fill_start = 1'b1; fill_colour = 2'b01;
      tick();
      fill_start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         swap_req = (c == 5);
         if (fill_done && done_at < 0) done_at = c;
         if (swap_ack && ack_at < 0) ack_at = c;
         tick();
      end
      swap_req = 1'b0;
      n_checks += 3;
      if (done_at < 0) begin n_fail++; $display("FAIL db_done: fill_done never seen, expected one pulse"); end
      if (ack_at != done_at + 1) begin n_fail++; $display("FAIL db_ack_timing: ack at %0d expected %0d", ack_at, done_at + 1); end
      if (page !== 1'b1) begin n_fail++; $display("FAIL db_page: got %b expected 1", page); end
      for (int i = 0; i < 8; i++) begin rd_x[i] = i * 2; rd_y[i] = i; rd_e[i] = 1; end
      run_reads(8, "db_read");
   endtask
`endif

   initial begin
      test_reset();
`ifdef FRAMEBUFFER_FILL_DOUBLE_BUFFER_EN
      test_double_buffer();
`else
      test_write_read();
      test_fill();
      test_same_cycle();
      test_reset_mid_fill();
      test_back_to_back();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
